// File: rtl/load_store_unit_if.sv
// Pipeline-side and memory-side signals of the load/store unit.
//   master : the load/store unit. It takes the pipeline op, drives the memory request and
//            returns the completion.
//   slave  : the environment, which is the pipeline plus the data memory.
//   ls_*   : pipeline op (valid/we/funct3/addr/wdata in), busy/done/err/rdata out.
//   mem_*  : word-addressed memory port (req/we/addr/be/wdata out), gnt/rvalid/rdata in.
interface load_store_unit_if;
    logic        ls_valid;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_busy;
    logic        ls_done;
    logic        ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  ls_valid, ls_we, ls_funct3, ls_addr, ls_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ls_busy, ls_done, ls_err, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output ls_valid, ls_we, ls_funct3, ls_addr, ls_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ls_busy, ls_done, ls_err, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory with a req/gnt + rvalid handshake.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : load_store_unit_if.master. It carries the pipeline op and completion (ls_*)
//                and the memory request and response (mem_*).
// Every output is registered.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    load_store_unit_if.master       bus
);

    // The counter only has to reach TIMEOUT-2, the value it holds on the terminal cycle.
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_ERR    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_we_q, op_we_d;
    logic [2:0]         op_f3_q, op_f3_d;
    logic [1:0]         op_off_q, op_off_d;

    logic               ls_busy_q, ls_busy_d;
    logic               ls_done_q, ls_done_d;
    logic               ls_err_q, ls_err_d;
    logic [31:0]        ls_rdata_q, ls_rdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic               bad_op;
    logic [3:0]         be_new;
    logic [31:0]        wdata_new;
    logic [31:0]        load_data;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic               terminal;

    // Decode the incoming op: legality, byte enables and lane-replicated store data.
    always_comb begin
        bad_op    = 1'b0;
        be_new    = 4'b1111;
        wdata_new = bus.ls_wdata;
        unique case (bus.ls_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << bus.ls_addr[1:0];
                wdata_new = {4{bus.ls_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {bus.ls_addr[1], 1'b0};
                wdata_new = {2{bus.ls_wdata[15:0]}};
                bad_op    = bus.ls_addr[0];
            end
            2'b10: bad_op = (bus.ls_addr[1:0] != 2'b00);
            default: bad_op = 1'b1;
        endcase
        // BU/HU exist only for loads; 110 and 111 are not access widths at all.
        if (bus.ls_funct3[2] && (bus.ls_we || bus.ls_funct3[1]))
            bad_op = 1'b1;
    end

    // Select the lane of the returned word and extend it.
    always_comb begin
        rd_byte = bus.mem_rdata[{op_off_q, 3'b000} +: 8];
        rd_half = bus.mem_rdata[{op_off_q[1], 4'b0000} +: 16];
        unique case (op_f3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // The terminal cycle is the one in which the counter would step to TIMEOUT-1.
    assign terminal = (cnt_q == CNT_W'(TIMEOUT - 2));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_we_d     = op_we_q;
        op_f3_d     = op_f3_q;
        op_off_d    = op_off_q;
        ls_done_d   = 1'b0;
        ls_err_d    = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                // The done cycle itself never accepts, because the op is still presented then.
                if (bus.ls_valid && !ls_done_q) begin
                    cnt_d    = '0;
                    op_we_d  = bus.ls_we;
                    op_f3_d  = bus.ls_funct3;
                    op_off_d = bus.ls_addr[1:0];
                    if (bad_op) begin
                        state_d    = S_ERR;
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = '0;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.ls_we;
                        mem_addr_d  = {bus.ls_addr[31:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                    end
                end
            end
            S_ERR: state_d = S_IDLE;
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_gnt || terminal) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                end
                if (bus.mem_gnt) begin
                    if (op_we_q) begin
                        state_d    = S_IDLE;
                        ls_done_d  = 1'b1;
                        ls_rdata_d = '0;
                    end else begin
                        state_d = S_WAIT_R;
                    end
                end else if (terminal) begin
                    state_d    = S_IDLE;
                    ls_done_d  = 1'b1;
                    ls_err_d   = 1'b1;
                    ls_rdata_d = '0;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_rvalid) begin
                    state_d    = S_IDLE;
                    ls_done_d  = 1'b1;
                    ls_rdata_d = load_data;
                end else if (terminal) begin
                    state_d    = S_IDLE;
                    ls_done_d  = 1'b1;
                    ls_err_d   = 1'b1;
                    ls_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ls_busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            op_f3_q     <= '0;
            op_off_q    <= '0;
            ls_busy_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            op_f3_q     <= op_f3_d;
            op_off_q    <= op_off_d;
            ls_busy_q   <= ls_busy_d;
            ls_done_q   <= ls_done_d;
            ls_err_q    <= ls_err_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.ls_busy   = ls_busy_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. A memory responder grants requests and returns read data
// with programmable delays. Each test pushes its expected results to a scoreboard queue and pops
// them as the ops complete.
module tb_load_store_unit;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Responder controls and observations.
    int          gnt_delay = 0;
    int          rv_delay = 1;
    int          rv_cnt = -1;
    int          req_age = 0;
    int          gnt_cnt = 0;
    int          req_cycles = 0;
    bit          never_gnt = 1'b0;
    bit          inject_rv = 1'b0;
    bit          unstable = 1'b0;
    logic [31:0] rd_word = '0;
    logic [31:0] s_addr, s_wdata, g_addr, g_wdata;
    logic [3:0]  s_be, g_be;
    logic        s_we, g_we;

    // Memory responder: it drives gnt/rvalid/rdata at the negative edge.
    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
            if (!rst_n) begin
                rv_cnt = -1; req_age = 0;
            end else begin
                if (inject_rv) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = rd_word; inject_rv = 1'b0;
                end else if (rv_cnt == 0) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = rd_word; rv_cnt = -1;
                end else if (rv_cnt > 0) begin
                    rv_cnt--;
                end
                if (bus.mem_req) begin
                    req_cycles++;
                    if (req_age == 0) begin
                        s_addr = bus.mem_addr; s_be = bus.mem_be; s_wdata = bus.mem_wdata; s_we = bus.mem_we;
                    end else if (bus.mem_addr !== s_addr || bus.mem_be !== s_be ||
                                 bus.mem_wdata !== s_wdata || bus.mem_we !== s_we) begin
                        unstable = 1'b1;
                    end
                    req_age++;
                    if (!never_gnt && req_age > gnt_delay) begin
                        bus.mem_gnt = 1'b1; gnt_cnt++;
                        g_addr = bus.mem_addr; g_be = bus.mem_be; g_wdata = bus.mem_wdata; g_we = bus.mem_we;
                        if (!bus.mem_we) rv_cnt = rv_delay - 1;
                    end
                end else begin
                    req_age = 0;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Present one op and wait for ls_done. lat counts cycles from the accept cycle (-1 on no done).
    task automatic drive_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit keep,
                            output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        bus.ls_valid = 1'b1; bus.ls_we = we; bus.ls_funct3 = f3; bus.ls_addr = addr; bus.ls_wdata = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.ls_done !== 1'b1 && lat < 64);
        rd = bus.ls_rdata;
        err = bus.ls_err;
        if (bus.ls_done !== 1'b1) lat = -1;
        if (!keep) bus.ls_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ls_valid = 1'b0; bus.ls_we = 1'b0; bus.ls_funct3 = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ls_busy, bus.ls_done, bus.ls_err, bus.ls_rdata} !== 35'd0) begin
            failures++; $display("FAIL reset_ls got=%h exp=0", {bus.ls_busy, bus.ls_done, bus.ls_err, bus.ls_rdata});
        end
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 70'd0) begin
            failures++; $display("FAIL reset_mem got=%h exp=0", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ls_busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b req=%b exp=0", bus.ls_busy, bus.mem_req);
        end
    endtask

    task automatic test_lw();
        logic [31:0] rd; logic err; int lat; int g0; exp_t e;
        gnt_delay = 0; rv_delay = 1; rd_word = 32'hDEADBEEF; g0 = gnt_cnt;
        sb.push_back('{addr: 32'h10, be: 4'b1111, wdata: 32'h0, rdata: 32'hDEADBEEF, err: 1'b0, lat: 3});
        drive_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, err, lat);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin failures++; $display("FAIL lw_rdata got=%h exp=%h", rd, e.rdata); end
        checks++; if (err !== e.err) begin failures++; $display("FAIL lw_err got=%b exp=%b", err, e.err); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL lw_latency got=%0d exp=%0d", lat, e.lat); end
        checks++;
        if (gnt_cnt != g0 + 1 || g_addr !== e.addr || g_be !== e.be || g_we !== 1'b0) begin
            failures++; $display("FAIL lw_mem grants=%0d addr=%h be=%b we=%b exp grants=%0d addr=%h be=%b we=0",
                                 gnt_cnt - g0, g_addr, g_be, g_we, 1, e.addr, e.be);
        end
        @(negedge clk);
        checks++;
        if (bus.ls_rdata !== 32'hDEADBEEF || bus.ls_done !== 1'b0) begin
            failures++; $display("FAIL lw_hold rdata=%h done=%b exp rdata=deadbeef done=0", bus.ls_rdata, bus.ls_done);
        end
    endtask

    task automatic test_lb_lbu();
        logic [31:0] rd; logic err; int lat; exp_t e;
        logic [2:0] f3s [2] = '{3'b000, 3'b100};
        gnt_delay = 0; rv_delay = 1; rd_word = 32'h80FF_0000;
        sb.push_back('{addr: 32'h10, be: 4'b1000, wdata: 32'h0, rdata: 32'hFFFFFF80, err: 1'b0, lat: 3});
        sb.push_back('{addr: 32'h10, be: 4'b1000, wdata: 32'h0, rdata: 32'h00000080, err: 1'b0, lat: 3});
        for (int i = 0; i < 2; i++) begin
            drive_op(1'b0, f3s[i], 32'h13, 32'h0, 1'b0, rd, err, lat);
            e = sb.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || lat != e.lat) begin
                failures++; $display("FAIL lb_result[%0d] rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                                     i, rd, err, lat, e.rdata, e.err, e.lat);
            end
            checks++;
            if (g_be !== e.be || g_addr !== e.addr) begin
                failures++; $display("FAIL lb_mem[%0d] be=%b addr=%h exp be=%b addr=%h", i, g_be, g_addr, e.be, e.addr);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat; int g0; int r0; exp_t e;
        logic        wes  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b011, 3'b101, 3'b010};
        logic [31:0] adrs [5] = '{32'h02, 32'h01, 32'h00, 32'h00, 32'h21};
        for (int i = 0; i < 5; i++)
            sb.push_back('{addr: 32'h0, be: 4'b0, wdata: 32'h0, rdata: 32'h0, err: 1'b1, lat: 1});
        for (int i = 0; i < 5; i++) begin
            g0 = gnt_cnt; r0 = req_cycles;
            drive_op(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 1'b0, rd, err, lat);
            e = sb.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || lat != e.lat) begin
                failures++; $display("FAIL err_result[%0d] rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                                     i, rd, err, lat, e.rdata, e.err, e.lat);
            end
            checks++;
            if (req_cycles != r0 || gnt_cnt != g0) begin
                failures++; $display("FAIL err_no_req[%0d] req_cycles=%0d exp=0", i, req_cycles - r0);
            end
        end
    endtask

    task automatic test_sh_delayed();
        logic [31:0] rd; logic err; int lat; int extra; exp_t e;
        gnt_delay = 3; unstable = 1'b0;
        sb.push_back('{addr: 32'h04, be: 4'b1100, wdata: 32'hABCDABCD, rdata: 32'h0, err: 1'b0, lat: 5});
        drive_op(1'b1, 3'b001, 32'h06, 32'h1234ABCD, 1'b0, rd, err, lat);
        e = sb.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || lat != e.lat) begin
            failures++; $display("FAIL sh_result rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                                 rd, err, lat, e.rdata, e.err, e.lat);
        end
        checks++;
        if (g_addr !== e.addr || g_be !== e.be || g_wdata !== e.wdata || g_we !== 1'b1) begin
            failures++; $display("FAIL sh_mem addr=%h be=%b wdata=%h we=%b exp addr=%h be=%b wdata=%h we=1",
                                 g_addr, g_be, g_wdata, g_we, e.addr, e.be, e.wdata);
        end
        checks++; if (unstable !== 1'b0) begin failures++; $display("FAIL sh_stable got=%b exp=0", unstable); end
        extra = 0;
        repeat (4) begin @(negedge clk); if (bus.ls_done === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL sh_single_done extra=%0d exp=0", extra); end
        gnt_delay = 0;
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic err; int lat; int g0; int extra; exp_t e;
        int          dly [3] = '{14, 15, 13};
        logic        wes [3] = '{1'b1, 1'b1, 1'b0};
        never_gnt = 1'b1; g0 = gnt_cnt;
        sb.push_back('{addr: 32'h40, be: 4'b1111, wdata: 32'h0, rdata: 32'h0, err: 1'b1, lat: 16});
        drive_op(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd, err, lat);
        e = sb.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || lat != e.lat) begin
            failures++; $display("FAIL to_result rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                                 rd, err, lat, e.rdata, e.err, e.lat);
        end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL to_req_drop got=%b exp=0", bus.mem_req); end
        never_gnt = 1'b0; rd_word = 32'h0000_0123; inject_rv = 1'b1; extra = 0;
        repeat (4) begin @(negedge clk); if (bus.ls_done === 1'b1 || bus.ls_busy === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL to_late_rvalid activity=%0d exp=0", extra); end
        // Response arriving on the terminal cycle wins; one cycle later is too late.
        rd_word = 32'h5A5A_0001; rv_delay = 1;
        sb.push_back('{addr: 32'h08, be: 4'b1111, wdata: 32'h0, rdata: 32'h0, err: 1'b0, lat: 16});
        sb.push_back('{addr: 32'h08, be: 4'b1111, wdata: 32'h0, rdata: 32'h0, err: 1'b1, lat: 16});
        sb.push_back('{addr: 32'h08, be: 4'b1111, wdata: 32'h0, rdata: 32'h5A5A0001, err: 1'b0, lat: 16});
        for (int i = 0; i < 3; i++) begin
            gnt_delay = dly[i];
            drive_op(wes[i], 3'b010, 32'h08, 32'h0BAD_F00D, 1'b0, rd, err, lat);
            e = sb.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || lat != e.lat) begin
                failures++; $display("FAIL to_terminal[%0d] rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                                     i, rd, err, lat, e.rdata, e.err, e.lat);
            end
        end
        gnt_delay = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat; exp_t e;
        logic        wes [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{3'b000, 3'b001, 3'b101, 3'b010};
        logic [31:0] ads [4] = '{32'h01, 32'h02, 32'h00, 32'h0C};
        logic [31:0] wds [4] = '{32'h0000_00A5, 32'h0, 32'h0, 32'hCAFE_F00D};
        gnt_delay = 0; rv_delay = 1; rd_word = 32'h8001_7FFF;
        sb.push_back('{addr: 32'h00, be: 4'b0010, wdata: 32'hA5A5A5A5, rdata: 32'h0, err: 1'b0, lat: 2});
        sb.push_back('{addr: 32'h00, be: 4'b1100, wdata: 32'h0, rdata: 32'hFFFF8001, err: 1'b0, lat: 3});
        sb.push_back('{addr: 32'h00, be: 4'b0011, wdata: 32'h0, rdata: 32'h00007FFF, err: 1'b0, lat: 3});
        sb.push_back('{addr: 32'h0C, be: 4'b1111, wdata: 32'hCAFEF00D, rdata: 32'h0, err: 1'b0, lat: 2});
        for (int i = 0; i < 4; i++) begin
            drive_op(wes[i], f3s[i], ads[i], wds[i], 1'b0, rd, err, lat);
            e = sb.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || lat != e.lat) begin
                failures++; $display("FAIL b2b_result[%0d] rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                                     i, rd, err, lat, e.rdata, e.err, e.lat);
            end
            checks++;
            if (g_addr !== e.addr || g_be !== e.be || (wes[i] && g_wdata !== e.wdata)) begin
                failures++; $display("FAIL b2b_mem[%0d] addr=%h be=%b wdata=%h exp addr=%h be=%b wdata=%h",
                                     i, g_addr, g_be, g_wdata, e.addr, e.be, e.wdata);
            end
        end
        // Leave the op presented through its done cycle: it must not be accepted again there.
        drive_op(1'b1, 3'b010, 32'h20, 32'h1, 1'b1, rd, err, lat);
        @(negedge clk);
        checks++;
        if (bus.ls_busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL b2b_no_accept_in_done busy=%b req=%b exp 0 0", bus.ls_busy, bus.mem_req);
        end
        bus.ls_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int extra;
        gnt_delay = 0; rv_delay = 6; rd_word = 32'h1111_2222;
        @(negedge clk);
        bus.ls_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_funct3 = 3'b010; bus.ls_addr = 32'h30;
        repeat (3) @(negedge clk);
        checks++; if (bus.ls_busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", bus.ls_busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ls_busy, bus.ls_done, bus.ls_err, bus.ls_rdata, bus.mem_req, bus.mem_we,
             bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 105'd0) begin
            failures++; $display("FAIL rst_midop_outputs busy=%b done=%b rdata=%h req=%b addr=%h exp all 0",
                                 bus.ls_busy, bus.ls_done, bus.ls_rdata, bus.mem_req, bus.mem_addr);
        end
        bus.ls_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        inject_rv = 1'b1; extra = 0;
        repeat (6) begin @(negedge clk); if (bus.ls_done === 1'b1 || bus.ls_busy === 1'b1) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL rst_rvalid_ignored activity=%0d exp=0", extra); end
        rv_delay = 1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_errors();
        test_sh_delayed();
        test_timeout();
        test_back_to_back();
        test_lw();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
